// File: rtl/bist_pattern_engine_if.sv
// Handshake/bus bundle between the BIST controller (master) and the pattern engine (slave).
// Scalar clk/rst stay as plain module ports.
interface bist_pattern_engine_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             step_en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_patterns;
    logic [WIDTH-1:0] expected_sig;
    logic [WIDTH-1:0] resp_in;
    logic [WIDTH-1:0] pattern;
    logic             pattern_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;

    modport master (
        output start, step_en, mode, num_patterns, expected_sig, resp_in,
        input  pattern, pattern_valid, busy, done, pass, signature
    );

    modport slave (
        input  start, step_en, mode, num_patterns, expected_sig, resp_in,
        output pattern, pattern_valid, busy, done, pass, signature
    );
endinterface

// File: rtl/bist_pattern_engine.sv
// BIST pattern generator (ring / Johnson / LFSR / up-count) with MISR response compaction
// and final signature compare. Advances only on step_en; runs from a single clock.
module bist_pattern_engine #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] MISR_TAPS = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(16'h0001),
    parameter int               CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    bist_pattern_engine_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEED = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_RING  = 2'b00;
    localparam logic [1:0] M_JOHN  = 2'b01;
    localparam logic [1:0] M_LFSR  = 2'b10;
    localparam logic [1:0] M_COUNT = 2'b11;

    // An all-zero LFSR seed would lock up, so it is replaced by 1.
    localparam logic [WIDTH-1:0] LFSR_START = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] sig_q;
    logic             pass_q;

    logic             step;
    logic             last_step;
    logic [WIDTH-1:0] seed_pat;
    logic [WIDTH-1:0] next_pat;
    logic [WIDTH-1:0] next_sig;

    assign step      = (state == S_RUN) && bus.step_en;
    assign last_step = (count == num_q - CNT_W'(1));
    assign next_sig  = {sig_q[WIDTH-2:0], ^(sig_q & MISR_TAPS)} ^ bus.resp_in;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        seed_pat = '0;
        case (mode_q)
            M_RING:  seed_pat = WIDTH'(1);
            M_LFSR:  seed_pat = LFSR_START;
            default: seed_pat = '0;
        endcase
    end

    always_comb begin
        next_pat = pattern_q;
        case (mode_q)
            M_RING:  next_pat = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            M_JOHN:  next_pat = {pattern_q[WIDTH-2:0], ~pattern_q[WIDTH-1]};
            M_LFSR:  next_pat = {pattern_q[WIDTH-2:0], ^(pattern_q & LFSR_TAPS)};
            M_COUNT: next_pat = pattern_q + WIDTH'(1);
            default: next_pat = pattern_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            num_q     <= '0;
            exp_q     <= '0;
            count     <= '0;
            pattern_q <= '0;
            sig_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_SEED;
                        mode_q <= bus.mode;
                        num_q  <= bus.num_patterns;
                        exp_q  <= bus.expected_sig;
                        pass_q <= 1'b0;
                    end
                end
                S_SEED: begin
                    pattern_q <= seed_pat;
                    sig_q     <= '0;
                    count     <= '0;
                    if (num_q == '0) begin
                        state  <= S_DONE;
                        pass_q <= (exp_q == '0);
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        pattern_q <= next_pat;
                        sig_q     <= next_sig;
                        count     <= count + CNT_W'(1);
                        // pass is captured from the final signature as DONE is entered.
                        if (last_step) begin
                            state  <= S_DONE;
                            pass_q <= (next_sig == exp_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pattern       = pattern_q;
    assign bus.signature     = sig_q;
    assign bus.pattern_valid = step;
    assign bus.busy          = (state == S_SEED) || (state == S_RUN);
    assign bus.done          = (state == S_DONE);
    assign bus.pass          = pass_q;
endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench for bist_pattern_engine at WIDTH=4, CNT_W=6, taps 4'b1001.
// Patterns and signatures are predicted from closed-form sequences and the MISR rule.
module tb_bist_pattern_engine;
    localparam int W  = 4;
    localparam int CW = 6;
    localparam logic [W-1:0] TAPS = 4'b1001;
    localparam logic [W-1:0] SEED = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bist_pattern_engine_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    bist_pattern_engine #(
        .WIDTH(W), .LFSR_TAPS(TAPS), .MISR_TAPS(TAPS), .LFSR_SEED(SEED), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] obs[$];  // patterns seen with pattern_valid=1 in the latest run

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] p);
        return {p[W-2:0], ^(p & TAPS)};
    endfunction

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] r);
        return {s[W-2:0], ^(s & TAPS)} ^ r;
    endfunction

    // k-th pattern of a run (k=0 is the seed).
    function automatic logic [W-1:0] pat_at(input logic [1:0] m, input int k);
        logic [W-1:0] p;
        int j;
        case (m)
            2'b00: return W'(1 << (k % W));
            2'b01: begin
                j = k % (2 * W);
                if (j <= W) return W'((1 << j) - 1);
                else        return W'(~((1 << (j - W)) - 1));
            end
            2'b10: begin
                p = SEED;
                for (int i = 0; i < k; i++) p = lfsr_step(p);
                return p;
            end
            default: return W'(k);
        endcase
    endfunction

    // stall_kind: 0 always step, 1 toggle 1010.., 2 random; resp_kind: 0 zero, 1 random, 2 loopback.
    task automatic do_run(input logic [1:0] m, input int n, input bit match,
                          input int stall_kind, input int resp_kind, input bit mid_start);
        logic [W-1:0] resp_tab[64];
        logic [W-1:0] sig, expsig;
        int k, nv, cyc;
        bit st;
        sig = '0;
        for (int i = 0; i < n; i++) begin
            case (resp_kind)
                0:       resp_tab[i] = '0;
                1:       resp_tab[i] = W'($urandom);
                default: resp_tab[i] = pat_at(m, i);
            endcase
            sig = misr_step(sig, resp_tab[i]);
        end
        expsig = match ? sig : (sig ^ W'(1));
        obs.delete();

        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.num_patterns = CW'(n);
        bus.expected_sig = expsig; bus.step_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mode = 2'($urandom); bus.num_patterns = CW'($urandom);
        bus.expected_sig = W'($urandom);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.pattern_valid !== 1'b0)
            begin errors++; $display("FAIL seed_cycle: busy=%b done=%b pass=%b valid=%b, want 1 0 0 0",
                bus.busy, bus.done, bus.pass, bus.pattern_valid); end

        k = 0; nv = 0; cyc = 0;
        while (k < n && cyc < 4 * n + 8) begin
            @(negedge clk);
            cyc++;
            case (stall_kind)
                0:       st = 1'b1;
                1:       st = (cyc % 2 == 1);
                default: st = ($urandom_range(0, 3) != 0);
            endcase
            bus.step_en = st;
            bus.resp_in = st ? resp_tab[k] : W'($urandom);
            bus.start = mid_start && (k == 2);
            bus.mode = 2'($urandom); bus.num_patterns = CW'($urandom); bus.expected_sig = W'($urandom);
            #1;
            checks++;
            if (bus.pattern_valid !== st || bus.pattern !== pat_at(m, k) || bus.busy !== 1'b1 || bus.done !== 1'b0)
                begin errors++; $display("FAIL run_step mode=%0d k=%0d: valid=%b pattern=%b busy=%b done=%b, want %b %b 1 0",
                    m, k, bus.pattern_valid, bus.pattern, bus.busy, bus.done, st, pat_at(m, k)); end
            if (bus.pattern_valid === 1'b1) begin obs.push_back(bus.pattern); nv++; end
            if (st) k++;
        end

        @(negedge clk);
        bus.step_en = 1'b1; bus.start = 1'b0;
        #1;
        checks++;
        if (k != n) begin errors++; $display("FAIL run_timeout: consumed %0d of %0d patterns", k, n); end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pattern_valid !== 1'b0)
            begin errors++; $display("FAIL done_status n=%0d: done=%b busy=%b valid=%b, want 1 0 0",
                n, bus.done, bus.busy, bus.pattern_valid); end
        checks++;
        if (bus.signature !== sig)
            begin errors++; $display("FAIL signature mode=%0d n=%0d: got %b want %b", m, n, bus.signature, sig); end
        checks++;
        if (bus.pass !== match)
            begin errors++; $display("FAIL pass n=%0d: got %b want %b", n, bus.pass, match); end
        checks++;
        if (bus.pattern !== pat_at(m, n))
            begin errors++; $display("FAIL done_pattern: got %b want %b", bus.pattern, pat_at(m, n)); end
        checks++;
        if (nv != n) begin errors++; $display("FAIL valid_count: got %0d want %0d", nv, n); end
    endtask

    task automatic check_obs(input string name, input int idx, input logic [W-1:0] want);
        checks++;
        if (idx >= obs.size()) begin
            errors++; $display("FAIL %s[%0d]: missing, want %b", name, idx, want);
        end else if (obs[idx] !== want) begin
            errors++; $display("FAIL %s[%0d]: got %b want %b", name, idx, obs[idx], want);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.step_en = 1'b0; bus.mode = '0;
        bus.num_patterns = '0; bus.expected_sig = '0; bus.resp_in = '0;
        rst = 1'b0;
        #12;
        checks++;
        if (bus.pattern !== '0 || bus.signature !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0)
            begin errors++; $display("FAIL reset_state: pattern=%b sig=%b busy=%b done=%b pass=%b, want all 0",
                bus.pattern, bus.signature, bus.busy, bus.done, bus.pass); end
        @(negedge clk); rst = 1'b1;

        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b10; bus.num_patterns = CW'(20); bus.step_en = 1'b1;
        bus.resp_in = W'($urandom);
        @(negedge clk); bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_prerun: busy=%b want 1", bus.busy); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.pattern !== '0 || bus.signature !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.pass !== 1'b0 || bus.pattern_valid !== 1'b0)
            begin errors++; $display("FAIL reset_midrun: pattern=%b sig=%b busy=%b done=%b pass=%b valid=%b, want all 0",
                bus.pattern, bus.signature, bus.busy, bus.done, bus.pass, bus.pattern_valid); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL reset_hold: done=%b busy=%b want 0 0", bus.done, bus.busy); end
        rst = 1'b1;
        do_run(2'b10, 6, 1'b1, 0, 1, 1'b0);
    endtask

    task automatic test_ring_johnson();
        logic [W-1:0] ring_tab[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [W-1:0] john_tab[8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        do_run(2'b00, 8, 1'b1, 0, 1, 1'b0);
        for (int i = 0; i < 8; i++) check_obs("ring", i, ring_tab[i]);
        do_run(2'b01, 8, 1'b1, 0, 1, 1'b0);
        for (int i = 0; i < 8; i++) check_obs("johnson", i, john_tab[i]);
    endtask

    task automatic test_lfsr();
        logic [W-1:0] lfsr_tab[15] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010,
                                       4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000};
        do_run(2'b10, 16, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 15; i++) check_obs("lfsr", i, lfsr_tab[i]);
        check_obs("lfsr_wrap", 15, 4'b0001);
    endtask

    task automatic test_misr_pass();
        do_run(2'b11, 10, 1'b1, 0, 0, 1'b0);
        do_run(2'b11, 10, 1'b0, 0, 0, 1'b0);
        do_run(2'b11, 20, 1'b1, 0, 2, 1'b0);
        do_run(2'b11, 20, 1'b0, 0, 2, 1'b0);
    endtask

    task automatic test_stall_ignored_start();
        do_run(2'b00, 6, 1'b1, 1, 1, 1'b1);
        do_run(2'b10, 12, 1'b0, 2, 1, 1'b1);
    endtask

    task automatic test_edge_counts();
        do_run(2'b01, 0, 1'b1, 0, 1, 1'b0);
        do_run(2'b01, 0, 1'b0, 0, 1, 1'b0);
        do_run(2'b11, 18, 1'b1, 0, 1, 1'b0);
        check_obs("count_top", 15, 4'b1111);
        check_obs("count_wrap", 16, 4'b0000);
        do_run(2'b00, 3, 1'b1, 0, 1, 1'b0);
        do_run(2'b01, 4, 1'b1, 0, 1, 1'b0);
        check_obs("restart_mode", 1, 4'b0001);
        do_run(2'b11, (1 << CW) - 1, 1'b1, 2, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++)
            do_run(2'($urandom), $urandom_range(1, 20), 1'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 2), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_ring_johnson();
        test_lfsr();
        test_misr_pass();
        test_stall_ignored_start();
        test_edge_counts();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
